// File: rtl/ifetch_assembler.sv
// Multicycle instruction fetch: assembles an INSTR_W-bit instruction from
// INSTR_W/DATA_W consecutive memory beats (little-endian), maintains the PC
// and accepts branch/jump redirects, which also abort a fetch in flight.
//
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   start               fetch the instruction at pc (or at redirect_pc if redirect)
//   redirect/_pc        load pc / abort current fetch
//   mem_rd, mem_adr     memory read strobe and byte address
//   mem_rdata/_ready    beat data and beat-accept handshake
//   instr, instr_valid  last completed instruction, one-cycle update pulse
//   busy                fetch in progress
//   pc, pc_cur          next fetch address, address of instr
//   beat                current beat index
module ifetch_assembler #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned INSTR_W  = 32,
  parameter int unsigned ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  localparam int unsigned Beats = INSTR_W / DATA_W,
  localparam int unsigned BeatW = (Beats > 1) ? $clog2(Beats) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               mem_rd,
  output logic [ADDR_W-1:0]  mem_adr,
  input  logic [DATA_W-1:0]  mem_rdata,
  input  logic               mem_ready,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic               busy,
  output logic [ADDR_W-1:0]  pc,
  output logic [ADDR_W-1:0]  pc_cur,
  output logic [BeatW-1:0]   beat
);

  typedef enum logic [0:0] {StIdle, StFetch} state_e;

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    base_q;
  logic [BeatW-1:0]     beat_q;
  logic [INSTR_W-1:0]   shadow_q;
  logic [INSTR_W-1:0]   instr_q;
  logic [ADDR_W-1:0]    pc_q;
  logic [ADDR_W-1:0]    pc_cur_q;
  logic                 valid_q;
  logic [INSTR_W-1:0]   assembled;
  logic                 last_beat;

  assign last_beat = (beat_q == BeatW'(Beats - 1));

  // Shadow word with the current beat merged in; on the last beat this is
  // the complete instruction.
  always_comb begin
    assembled = shadow_q;
    assembled[beat_q * DATA_W +: DATA_W] = mem_rdata;
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; redirect takes priority over beat completion.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StFetch;
      end
      StFetch: begin
        if (redirect) begin
          state_d = StIdle;
        end else if (mem_ready && last_beat) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    mem_rd  = (state_q == StFetch);
    busy    = (state_q == StFetch);
    mem_adr = (state_q == StFetch) ? base_q + ADDR_W'(beat_q) : pc_q;
  end

  // Datapath
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      base_q   <= RESET_PC;
      beat_q   <= '0;
      shadow_q <= '0;
      instr_q  <= '0;
      pc_q     <= RESET_PC;
      pc_cur_q <= RESET_PC;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            base_q <= redirect ? redirect_pc : pc_q;
            beat_q <= '0;
          end else if (redirect) begin
            pc_q <= redirect_pc;
          end
        end
        StFetch: begin
          if (redirect) begin
            // Abort: partial beats stay in the shadow and are discarded.
            pc_q   <= redirect_pc;
            beat_q <= '0;
          end else if (mem_ready) begin
            shadow_q <= assembled;
            if (last_beat) begin
              instr_q  <= assembled;
              pc_cur_q <= base_q;
              pc_q     <= base_q + ADDR_W'(Beats);
              valid_q  <= 1'b1;
              beat_q   <= '0;
            end else begin
              beat_q <= beat_q + BeatW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign pc_cur      = pc_cur_q;
  assign beat        = beat_q;

endmodule

// File: tb/tb_ifetch_assembler.sv
module tb_ifetch_assembler;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, redirect, mem_ready;
  logic [7:0]  redirect_pc;
  logic        mem_rd, instr_valid, busy;
  logic [7:0]  mem_adr, pc, pc_cur;
  logic [7:0]  mem_rdata;
  logic [31:0] instr;
  logic [1:0]  beat;

  // Sweep instances: 16/32 and 8/16, both two beats, always ready.
  logic        s_start;
  logic        d1_rd, d1_valid, d1_busy, d2_rd, d2_valid, d2_busy;
  logic [7:0]  d1_adr, d1_pc, d1_pc_cur, d2_adr, d2_pc, d2_pc_cur;
  logic [15:0] d1_rdata;
  logic [7:0]  d2_rdata;
  logic [31:0] d1_instr;
  logic [15:0] d2_instr;
  logic [0:0]  d1_beat, d2_beat;

  logic [31:0] mem [256];
  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [7:0]  m_pc, m_pc_cur;
  logic [31:0] m_instr;

  assign mem_rdata = mem[mem_adr][7:0];
  assign d1_rdata  = mem[d1_adr][15:0];
  assign d2_rdata  = mem[d2_adr][7:0];

  always #5 clk = ~clk;

  ifetch_assembler #(.DATA_W(8), .INSTR_W(32), .ADDR_W(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .reset(reset), .start(start), .redirect(redirect),
    .redirect_pc(redirect_pc), .mem_rd(mem_rd), .mem_adr(mem_adr),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .instr(instr),
    .instr_valid(instr_valid), .busy(busy), .pc(pc), .pc_cur(pc_cur), .beat(beat)
  );

  ifetch_assembler #(.DATA_W(16), .INSTR_W(32), .ADDR_W(8), .RESET_PC(8'h00)) dut16 (
    .clk(clk), .reset(reset), .start(s_start), .redirect(1'b0),
    .redirect_pc(8'h00), .mem_rd(d1_rd), .mem_adr(d1_adr),
    .mem_rdata(d1_rdata), .mem_ready(1'b1), .instr(d1_instr),
    .instr_valid(d1_valid), .busy(d1_busy), .pc(d1_pc), .pc_cur(d1_pc_cur), .beat(d1_beat)
  );

  ifetch_assembler #(.DATA_W(8), .INSTR_W(16), .ADDR_W(8), .RESET_PC(8'h00)) dut8 (
    .clk(clk), .reset(reset), .start(s_start), .redirect(1'b0),
    .redirect_pc(8'h00), .mem_rd(d2_rd), .mem_adr(d2_adr),
    .mem_rdata(d2_rdata), .mem_ready(1'b1), .instr(d2_instr),
    .instr_valid(d2_valid), .busy(d2_busy), .pc(d2_pc), .pc_cur(d2_pc_cur), .beat(d2_beat)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full fetch from IDLE; ends in the instr_valid cycle (still IDLE).
  task automatic do_fetch(input int wait_beat, input int nwait, input bit hold_start,
                          input bit use_redir, input logic [7:0] rpc);
    logic [7:0]  base, a;
    logic [31:0] exp_instr;
    base = use_redir ? rpc : m_pc;
    for (int i = 0; i < 4; i++) begin
      a = base + 8'(i);
      exp_instr[i*8 +: 8] = mem[a][7:0];
    end
    start = 1'b1; redirect = use_redir; redirect_pc = rpc; mem_ready = 1'b1;
    step();
    start = hold_start; redirect = 1'b0;
    chk("valid_low_in_fetch", 32'(instr_valid), 32'd0);
    for (int b = 0; b < 4; b++) begin
      a = base + 8'(b);
      if (b == wait_beat) begin
        for (int w = 0; w < nwait; w++) begin
          mem_ready = 1'b0;
          chk("adr_wait", 32'(mem_adr), 32'(a));
          chk("beat_wait", 32'(beat), 32'(b));
          step();
        end
      end
      mem_ready = 1'b1;
      chk("adr", 32'(mem_adr), 32'(a));
      chk("busy", 32'(busy), 32'd1);
      chk("mem_rd", 32'(mem_rd), 32'd1);
      chk("instr_stable", instr, m_instr);
      step();
    end
    start = 1'b0;
    m_pc = base + 8'd4; m_pc_cur = base; m_instr = exp_instr;
    chk("valid_pulse", 32'(instr_valid), 32'd1);
    chk("instr", instr, m_instr);
    chk("pc", 32'(pc), 32'(m_pc));
    chk("pc_cur", 32'(pc_cur), 32'(m_pc_cur));
    chk("busy_done", 32'(busy), 32'd0);
  endtask

  // Start a fetch and redirect during beat at_beat (that beat is offered too).
  task automatic abort(input int at_beat, input logic [7:0] rpc);
    start = 1'b1; mem_ready = 1'b1;
    step();
    start = 1'b0;
    for (int b = 0; b < at_beat; b++) step();
    redirect = 1'b1; redirect_pc = rpc;
    step();
    redirect = 1'b0;
    m_pc = rpc;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_rd", 32'(mem_rd), 32'd0);
    chk("abort_valid", 32'(instr_valid), 32'd0);
    chk("abort_instr", instr, m_instr);
    chk("abort_pc_cur", 32'(pc_cur), 32'(m_pc_cur));
    chk("abort_pc", 32'(pc), 32'(m_pc));
    chk("abort_adr", 32'(mem_adr), 32'(m_pc));
    step();
    chk("abort_no_valid", 32'(instr_valid), 32'd0);
  endtask

  task automatic idle_redirect(input logic [7:0] rpc);
    redirect = 1'b1; redirect_pc = rpc;
    step();
    redirect = 1'b0;
    m_pc = rpc;
    chk("idle_redir_pc", 32'(pc), 32'(m_pc));
    chk("idle_redir_adr", 32'(mem_adr), 32'(m_pc));
    chk("idle_redir_busy", 32'(busy), 32'd0);
  endtask

  task automatic sweep_fetch(input logic [7:0] base);
    logic [7:0] a0, a1;
    a0 = base; a1 = base + 8'd1;
    s_start = 1'b1;
    step();
    s_start = 1'b0;
    chk("sw16_adr0", 32'(d1_adr), 32'(a0));
    chk("sw8_adr0", 32'(d2_adr), 32'(a0));
    step();
    chk("sw16_adr1", 32'(d1_adr), 32'(a1));
    chk("sw8_adr1", 32'(d2_adr), 32'(a1));
    step();
    chk("sw16_valid", 32'(d1_valid), 32'd1);
    chk("sw8_valid", 32'(d2_valid), 32'd1);
    chk("sw16_instr", d1_instr, {mem[a1][15:0], mem[a0][15:0]});
    chk("sw8_instr", 32'(d2_instr), 32'({mem[a1][7:0], mem[a0][7:0]}));
    chk("sw16_pc", 32'(d1_pc), 32'(base + 8'd2));
    chk("sw8_pc", 32'(d2_pc), 32'(base + 8'd2));
    chk("sw16_pc_cur", 32'(d1_pc_cur), 32'(base));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    int kind;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[0][7:0] = 8'h20; mem[1][7:0] = 8'h08; mem[2][7:0] = 8'h00; mem[3][7:0] = 8'h05;
    start = 1'b0; redirect = 1'b0; redirect_pc = 8'h00; mem_ready = 1'b1; s_start = 1'b0;
    m_pc = 8'h00; m_pc_cur = 8'h00; m_instr = 32'h0;

    reset = 1'b0;
    #2;
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_pc_cur", 32'(pc_cur), 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rd", 32'(mem_rd), 32'd0);
    chk("rst_beat", 32'(beat), 32'd0);
    chk("rst_adr", 32'(mem_adr), 32'h0);
    #10 reset = 1'b1;
    step();

    // Zero-wait fetch of the known word at 0..3.
    do_fetch(9, 0, 1'b0, 1'b0, 8'h00);
    chk("plan_instr", instr, 32'h05000820);
    chk("plan_pc", 32'(pc), 32'h04);
    step();
    chk("valid_one_cycle", 32'(instr_valid), 32'd0);

    // Same fetch with two wait cycles on beat 1, start held (ignored) in FETCH.
    idle_redirect(8'h00);
    do_fetch(1, 2, 1'b1, 1'b0, 8'h00);
    chk("wait_instr", instr, 32'h05000820);
    // Back-to-back start in the valid cycle.
    do_fetch(9, 0, 1'b0, 1'b0, 8'h00);

    // Abort at beat 2, then fetch at the new target.
    abort(2, 8'h40);
    do_fetch(9, 0, 1'b0, 1'b0, 8'h00);
    chk("after_abort_pc_cur", 32'(pc_cur), 32'h40);

    // Address wrap.
    idle_redirect(8'hFE);
    do_fetch(9, 0, 1'b0, 1'b0, 8'h00);
    chk("wrap_pc", 32'(pc), 32'h02);

    for (int it = 0; it < 30; it++) begin
      kind = $urandom_range(0, 3);
      case (kind)
        0, 1: do_fetch($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 8'($urandom));
        2: abort($urandom_range(0, 3), 8'($urandom));
        default: idle_redirect(8'($urandom));
      endcase
    end

    // Reset pulse in the middle of a fetch.
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    #1 reset = 1'b0;
    #1;
    m_pc = 8'h00; m_pc_cur = 8'h00; m_instr = 32'h0;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_rd", 32'(mem_rd), 32'd0);
    chk("mid_rst_pc", 32'(pc), 32'h0);
    chk("mid_rst_pc_cur", 32'(pc_cur), 32'h0);
    chk("mid_rst_instr", instr, 32'h0);
    chk("mid_rst_beat", 32'(beat), 32'd0);
    chk("mid_rst_adr", 32'(mem_adr), 32'h0);
    chk("mid_rst_valid", 32'(instr_valid), 32'd0);
    #2 reset = 1'b1;
    step();
    do_fetch(9, 0, 1'b0, 1'b0, 8'h00);
    chk("post_rst_pc_cur", 32'(pc_cur), 32'h00);

    // Two-beat configurations.
    step();
    sweep_fetch(8'h00);
    sweep_fetch(8'h02);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ifetch_assembler.md
# ifetch_assembler

Parametrised multicycle instruction-fetch unit for the narrow-datapath processor. It assembles an INSTR_W-bit instruction from consecutive DATA_W-bit memory beats, maintains the program counter, and accepts branch/jump redirects. It sits between the control FSM and the shared memory port. It generalises the fixed four-byte, four-irwrite fetch sequence in three ways: any width ratio, memory wait states through `mem_ready`, and fetch abort on redirect.

## Interface

Parameters:
- DATA_W, 8, memory data width per beat
- INSTR_W, 32, instruction width; must be an integer multiple of DATA_W (BEATS = INSTR_W/DATA_W, BEATS ≥ 1)
- ADDR_W, 8, byte-address and PC width
- RESET_PC, 0, PC value after reset

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  request fetch of the instruction at PC (control FSM)
- redirect  in  1  load PC from redirect_pc (branch/jump)
- redirect_pc  in  ADDR_W  new PC value
- mem_rd  out  1  memory read strobe
- mem_adr  out  ADDR_W  memory byte address
- mem_rdata  in  DATA_W  memory read data
- mem_ready  in  1  mem_rdata valid this cycle; beat accepted
- instr  out  INSTR_W  last completed instruction
- instr_valid  out  1  one-cycle pulse, instr updated
- busy  out  1  fetch in progress
- pc  out  ADDR_W  address of next instruction to fetch
- pc_cur  out  ADDR_W  address of the instruction held in instr
- beat  out  clog2(BEATS) (min 1)  current beat index

## Operation

- States: IDLE, FETCH.
- IDLE: mem_rd=0, mem_adr=pc, busy=0.
  - start=1 → latch base=(redirect ? redirect_pc : pc), beat=0, go to FETCH.
  - redirect=1 without start → pc<=redirect_pc, stay in IDLE.
- FETCH: mem_rd=1, busy=1, mem_adr=(base+beat) mod 2^ADDR_W.
  - mem_ready=1 → shadow[beat*DATA_W +: DATA_W]<=mem_rdata (little-endian: lowest address fills the low slice), beat<=beat+1.
  - mem_ready=0 → hold all state; mem_adr and mem_rd stay stable.
  - Last beat accepted (beat=BEATS-1 with mem_ready) → instr<=assembled word, pc_cur<=base, pc<=(base+BEATS) mod 2^ADDR_W, instr_valid<=1 for exactly one cycle, return to IDLE.
- Redirect during FETCH aborts the fetch: IDLE, pc<=redirect_pc, no instr_valid, and instr/pc_cur unchanged. Partial beats go to the shadow register only and are discarded. A beat accepted in the same cycle is discarded.
- start during FETCH is ignored (no queueing).
- Back-to-back: start may be asserted in the cycle instr_valid is high. That cycle is IDLE, so start is accepted.

## Timing

- Reset asserted (async, any state, including mid-fetch): state=IDLE, pc=RESET_PC, pc_cur=RESET_PC, instr=0, instr_valid=0, busy=0, mem_rd=0, beat=0, mem_adr=RESET_PC. Release is synchronous to the next rising edge.
- Latency with mem_ready tied high: start sampled at edge 0, beats captured at edges 1..BEATS, instr_valid high in the cycle after edge BEATS.
- Each low cycle of mem_ready adds one cycle.
- Default parameters, zero wait: 4 beat cycles, then valid, so a 5-cycle fetch period with back-to-back starts.
- Address arithmetic wraps modulo 2^ADDR_W for both mem_adr and pc.
- instr, pc_cur, and pc change only at the completion edge or on redirect/reset.

## Test plan

- Reset, then start with mem_ready=1 and memory bytes 0x20,0x08,0x00,0x05 at addresses 0..3 → mem_adr 0,1,2,3; instr=0x05000820; instr_valid pulse 1 cycle; pc=4, pc_cur=0.
- Same fetch with mem_ready low for 2 cycles during beat 1 → mem_adr holds 1 for those cycles; instr correct; valid 2 cycles later than zero-wait.
- Redirect to 0x40 during beat 2 of a fetch → busy drops next cycle; no instr_valid; instr keeps previous value; pc=0x40. Next start fetches 0x40..0x43.
- pc=0xFE, start → mem_adr 0xFE,0xFF,0x00,0x01; pc=0x02 after completion.
- Reset pulsed low mid-fetch → all outputs at reset values immediately; a fetch after release starts at RESET_PC.
- Parameter sweep DATA_W=16/INSTR_W=32 and DATA_W=8/INSTR_W=16 → 2 beats each; correct slice order; pc advances by 2.
